// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared states, PID codes and CRC constants for the USB transmitter.
package usb_tx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    // x^16+x^15+x^2+1 in bit-reversed form, for an LSB-first right-shifting CRC
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction
endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: serial USB CRC16, one data bit per enabled cycle, LSB first.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d;
    always_comb
        crc_d = clr ? CRC16_INIT
              : en  ? ((crc_q >> 1) ^ ((crc_q[0] ^ din) ? CRC16_POLY : 16'h0000))
              : crc_q;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) crc_q <= CRC16_INIT;
        else crc_q <= crc_d;
    assign crc = crc_q;
endmodule

// File: rtl/usb_transmitter.sv
// usb_transmitter: serializes SYNC, PID, optional payload+CRC16 and EOP onto D+/D-
// with bit stuffing and NRZI; payload comes from a show-ahead FIFO.
module usb_transmitter
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_read,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bcnt_q, bcnt_d, pid_q, pid_d;
    logic [15:0] sh_q, sh_d, crc, fld;
    logic [2:0] ones_q, ones_d;
    logic dp_q, dp_d, dm_q, dm_d, read_q, read_d, done_q, done_d;
    logic tick, stuff, last, in_bits, fdone, send, nbit, crc_clr, crc_en;

    assign tick    = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign stuff   = ones_q == 3'd6;
    assign last    = bcnt_q == 4'd0;
    assign in_bits = state_q inside {S_SYNC, S_PID, S_DATA, S_CRC};
    assign fdone   = tick && last && !stuff;

    usb_crc16 u_crc (.clk(clk), .n_rst(n_rst), .clr(crc_clr), .en(crc_en), .din(nbit), .crc(crc));

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            pid_q   <= '0;
            sh_q    <= '0;
            ones_q  <= '0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            pid_q   <= pid_d;
            sh_q    <= sh_d;
            ones_q  <= ones_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            read_q  <= read_d;
            done_q  <= done_d;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = tx_start ? S_SYNC : S_IDLE;
            S_SYNC:  state_d = fdone ? S_PID : S_SYNC;
            S_PID:   state_d = !fdone ? S_PID : !is_data_pid(pid_q) ? S_EOP : tx_empty ? S_CRC : S_DATA;
            S_DATA:  state_d = !fdone ? S_DATA : tx_empty ? S_CRC : S_DATA;
            S_CRC:   state_d = fdone ? S_EOP : S_CRC;
            S_EOP:   state_d = (tick && last) ? S_IDLE : S_EOP;
            default: state_d = S_IDLE;
        endcase
    end

    // Each bit boundary emits either a stuffed 0, the next bit of the current field, or the first bit of the next field.
    always_comb begin
        cnt_d   = (state_q == S_IDLE || tick) ? '0 : cnt_q + 1'b1;
        bcnt_d  = bcnt_q;
        pid_d   = pid_q;
        sh_d    = sh_q;
        ones_d  = ones_q;
        dp_d    = dp_q;
        dm_d    = dm_q;
        read_d  = 1'b0;
        done_d  = 1'b0;
        send    = 1'b0;
        nbit    = 1'b0;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        fld     = state_d == S_CRC ? ~crc : state_d == S_PID ? {8'h00, ~pid_q, pid_q} : {8'h00, tx_data};
        if (state_q == S_IDLE) begin
            if (tx_start) begin
                send    = 1'b1;
                nbit    = SYNC_BYTE[0];
                sh_d    = {9'h000, SYNC_BYTE[7:1]};
                bcnt_d  = 4'd7;
                pid_d   = tx_pid;
                crc_clr = 1'b1;
            end
        end else if (tick && in_bits) begin
            if (stuff) begin
                send = 1'b1;
            end else if (!last) begin
                send   = 1'b1;
                nbit   = sh_q[0];
                sh_d   = sh_q >> 1;
                bcnt_d = bcnt_q - 1'b1;
                crc_en = state_q == S_DATA;
            end else if (state_d == S_EOP) begin
                dp_d   = 1'b0;
                dm_d   = 1'b0;
                bcnt_d = 4'd2;
            end else begin
                send   = 1'b1;
                nbit   = fld[0];
                sh_d   = fld >> 1;
                bcnt_d = state_d == S_CRC ? 4'd15 : 4'd7;
                crc_en = state_d == S_DATA;
                read_d = state_d == S_DATA;
            end
        end else if (tick && state_q == S_EOP) begin
            bcnt_d = last ? bcnt_q : bcnt_q - 1'b1;
            dp_d   = bcnt_q == 4'd1 ? 1'b1 : dp_q;
            dm_d   = bcnt_q == 4'd1 ? 1'b0 : dm_q;
            done_d = last;
        end
        if (send) begin
            dp_d   = nbit ? dp_q : ~dp_q;
            dm_d   = ~dp_d;
            ones_d = nbit ? ones_q + 1'b1 : 3'd0;
        end
    end

    assign d_plus  = dp_q;
    assign d_minus = dm_q;
    assign tx_read = read_q;
    assign tx_done = done_q;
    assign tx_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_usb_transmitter.sv
// tb_usb_transmitter: directed packets decoded from the bus lines (NRZI + destuff)
// and compared against hand-derived byte streams and a CRC16 model.
module tb_usb_transmitter;
    localparam int CPB = 8;
    localparam logic [3:0] PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;

    logic clk, n_rst, tx_start, tx_empty, tx_read, d_plus, d_minus, tx_busy, tx_done;
    logic [3:0] tx_pid;
    logic [7:0] tx_data;

    usb_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_read(tx_read),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fmem [64];
    int rd_ptr = 0;
    int fifo_end = 0;
    assign tx_data  = fmem[rd_ptr[5:0]];
    assign tx_empty = rd_ptr >= fifo_end;
    always @(posedge clk) if (tx_read) rd_ptr <= rd_ptr + 1;

    int cyc = 0, busy_cyc = 0, dones = 0;
    int read_cyc[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_busy) busy_cyc <= busy_cyc + 1;
        if (tx_done) dones <= dones + 1;
        if (tx_read) read_cyc.push_back(cyc);
    end

    int n_cmp = 0, n_err = 0;
    int t0;
    logic [7:0] rx_q[$];
    int rx_left, rx_stuffs, rx_bad, rx_first_stuff;
    logic rx_seen_se0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc16_ref(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        foreach (q[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ q[i][k];
                c = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return ~c;
    endfunction

    task automatic load_fifo(input logic [7:0] q[$]);
        foreach (q[i]) fmem[6'(rd_ptr + i)] = q[i];
        fifo_end = rd_ptr + q.size();
    endtask

    task automatic send(input logic [3:0] p);
        tx_start = 1'b1;
        tx_pid = p;
        step();
        tx_start = 1'b0;
        t0 = cyc;
    endtask

    // Decode from the first bit cycle until SE0; leaves time at the first SE0 cycle.
    task automatic rx_pkt();
        logic prev, raw;
        logic [7:0] cur;
        int ones, nb, tot;
        rx_q.delete();
        prev = 1'b1; ones = 0; nb = 0; tot = 0; cur = 8'h00;
        rx_stuffs = 0; rx_bad = 0; rx_first_stuff = -1; rx_seen_se0 = 1'b0;
        for (int i = 0; i < 400 && !rx_seen_se0; i++) begin
            if (!d_plus && !d_minus) rx_seen_se0 = 1'b1;
            else begin
                raw = d_plus == prev;
                prev = d_plus;
                if (ones == 6) begin
                    ones = 0;
                    rx_stuffs++;
                    if (raw) rx_bad++;
                    if (rx_first_stuff < 0) rx_first_stuff = tot;
                end else begin
                    ones = raw ? ones + 1 : 0;
                    cur = {raw, cur[7:1]};
                    nb++; tot++;
                    if (nb == 8) begin rx_q.push_back(cur); nb = 0; end
                end
                repeat (CPB) step();
            end
        end
        rx_left = nb;
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_se0_seen"}, 32'(rx_seen_se0), 1);
        chk({tag, "_nbytes"}, rx_q.size(), exp.size());
        chk({tag, "_partial_bits"}, rx_left, 0);
        chk({tag, "_stuff_not_zero"}, rx_bad, 0);
        foreach (exp[i])
            chk($sformatf("%s_byte%0d", tag, i), i < rx_q.size() ? 32'(rx_q[i]) : 32'hdead, 32'(exp[i]));
    endtask

    task automatic check_eop(input string tag, input logic restart, input logic [3:0] p);
        int se0_n, j_n;
        se0_n = 0; j_n = 0;
        repeat (2 * CPB) begin if (!d_plus && !d_minus) se0_n++; step(); end
        repeat (CPB) begin if (d_plus && !d_minus) j_n++; step(); end
        chk({tag, "_se0_cycles"}, se0_n, 2 * CPB);
        chk({tag, "_j_cycles"}, j_n, CPB);
        chk({tag, "_done_pulse"}, 32'(tx_done), 1);
        chk({tag, "_busy_low"}, 32'(tx_busy), 0);
        if (restart) begin tx_start = 1'b1; tx_pid = p; end
        step();
        tx_start = 1'b0;
        t0 = cyc;
        chk({tag, "_done_cleared"}, 32'(tx_done), 0);
        chk({tag, "_busy_after"}, 32'(tx_busy), 32'(restart));
    endtask

    initial begin
        logic [7:0] e[$];
        logic [7:0] d[$];
        logic [15:0] c;
        int r0, r1, b0, d0;
        n_rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_dplus", 32'(d_plus), 1);
        chk("rst_dminus", 32'(d_minus), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_read", 32'(tx_read), 0);
        chk("rst_done", 32'(tx_done), 0);
        repeat (3) step();
        n_rst = 1'b1;
        repeat (2) step();

        // ACK: 16 bits, no stuffing, 152 busy cycles
        r0 = read_cyc.size(); b0 = busy_cyc; d0 = dones;
        send(PID_ACK);
        chk("ack_first_k", {30'h0, d_plus, d_minus}, 32'b01);
        chk("ack_busy_start", 32'(tx_busy), 1);
        rx_pkt();
        e = {8'h80, 8'hD2};
        check_rx("ack", e);
        chk("ack_stuffs", rx_stuffs, 0);
        check_eop("ack", 1'b0, 4'h0);
        chk("ack_busy_cycles", busy_cyc - b0, 152);
        chk("ack_dones", dones - d0, 1);
        chk("ack_reads", read_cyc.size() - r0, 0);

        // DATA0, empty FIFO: zero-length packet with CRC 0000
        r0 = read_cyc.size();
        send(PID_DATA0);
        rx_pkt();
        e = {8'h80, 8'hC3, 8'h00, 8'h00};
        check_rx("zlp", e);
        chk("zlp_stuffs", rx_stuffs, 0);
        check_eop("zlp", 1'b0, 4'h0);
        chk("zlp_reads", read_cyc.size() - r0, 0);

        // DATA0 with FF: stuff after 4th data bit; CRC of FF is FF00 (sent 00,FF)
        d = {8'hFF};
        load_fifo(d);
        r0 = read_cyc.size();
        send(PID_DATA0);
        rx_pkt();
        e = {8'h80, 8'hC3, 8'hFF, 8'h00, 8'hFF};
        check_rx("ff", e);
        chk("ff_stuffs", rx_stuffs, 2);
        chk("ff_first_stuff_pos", rx_first_stuff, 20);
        chk("ff_crc_model", rx_q.size() == 5 ? {16'h0, rx_q[4], rx_q[3]} : 32'hdead, 32'(crc16_ref(d)));
        check_eop("ff", 1'b0, 4'h0);
        chk("ff_reads", read_cyc.size() - r0, 1);

        // DATA1 with 01 02 03
        d = {8'h01, 8'h02, 8'h03};
        load_fifo(d);
        c = crc16_ref(d);
        r0 = read_cyc.size();
        send(PID_DATA1);
        rx_pkt();
        e = {8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, c[7:0], c[15:8]};
        check_rx("d1", e);
        chk("d1_reads", read_cyc.size() - r0, 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("d1_read%0d_cycle", k), r0 + k < read_cyc.size() ? read_cyc[r0 + k] - t0 : -1, 128 + 64 * k);
        check_eop("d1", 1'b0, 4'h0);

        // tx_start during PID ignored; restart in the tx_done cycle accepted
        d0 = dones;
        send(PID_ACK);
        fork
            rx_pkt();
            begin
                repeat (80) step();
                tx_start = 1'b1;
                tx_pid = PID_STALL;
                step();
                tx_start = 1'b0;
            end
        join
        e = {8'h80, 8'hD2};
        check_rx("ign", e);
        check_eop("ign", 1'b1, PID_NAK);
        rx_pkt();
        e = {8'h80, 8'h5A};
        check_rx("restart", e);
        check_eop("restart", 1'b0, 4'h0);
        chk("ign_dones", dones - d0, 2);

        // reset in the middle of a data byte
        d = {8'h00, 8'h00, 8'h00, 8'h00};
        load_fifo(d);
        r0 = read_cyc.size(); d0 = dones;
        send(PID_DATA0);
        repeat (130) step();
        for (int i = 0; i < 20 && d_plus; i++) step();
        chk("rst_mid_pre_k", 32'(d_plus), 0);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_dplus", 32'(d_plus), 1);
        chk("rst_mid_dminus", 32'(d_minus), 0);
        chk("rst_mid_busy", 32'(tx_busy), 0);
        r1 = read_cyc.size();
        chk("rst_mid_reads_before", r1 - r0, 1);
        repeat (3) step();
        n_rst = 1'b1;
        repeat (300) step();
        chk("rst_mid_reads_after", read_cyc.size(), r1);
        chk("rst_mid_busy_after", 32'(tx_busy), 0);
        chk("rst_mid_line_j", {30'h0, d_plus, d_minus}, 32'b10);
        chk("rst_mid_no_done", dones - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
